// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO; one shared add/sub, one step per cycle.
// Optional macro MULDIV_CANCEL_EN adds a `cancel` input that flushes an op in RUN/FIX.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
`ifdef MULDIV_CANCEL_EN
    input  logic             cancel,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   qr_q, qr_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   aorig_q, aorig_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;

    logic               cancel_w;
    logic               is_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     add_x, add_y;
    logic [WIDTH+1:0]   add_r;
    logic [2*WIDTH-1:0] prod;

`ifdef MULDIV_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? ((~x) + WIDTH'(1)) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x, input logic neg);
        return neg ? ((~x) + (2*WIDTH)'(1)) : x;
    endfunction

    assign is_signed = ~op[0];
    assign abs_a     = cond_neg(a, is_signed & a[WIDTH-1]);
    assign abs_b     = cond_neg(b, is_signed & b[WIDTH-1]);

    // Shared adder: multiply adds the multiplicand when the LSB of the multiplier is set;
    // divide subtracts the divisor from the remainder shifted left by one dividend bit.
    always_comb begin
        if (is_div_q) begin
            add_x = {acc_q, qr_q[WIDTH-1]};
            add_y = {1'b0, m_q};
        end else begin
            add_x = {1'b0, acc_q};
            add_y = qr_q[0] ? {1'b0, m_q} : '0;
        end
        add_r = {1'b0, add_x} + ({1'b0, add_y} ^ {(WIDTH+2){is_div_q}}) + (WIDTH+2)'(is_div_q);
    end

    assign prod = cond_neg2({acc_q, qr_q}, neg_res_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        qr_d      = qr_q;
        m_d       = m_q;
        aorig_d   = aorig_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start && !cancel_w) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    acc_d     = '0;
                    is_div_d  = op[1];
                    m_d       = op[1] ? abs_b : abs_a;
                    qr_d      = op[1] ? abs_a : abs_b;
                    aorig_d   = a;
                    neg_res_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = is_signed & a[WIDTH-1];
                    dz_d      = op[1] & (b == '0);
                end else if (!start) begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            S_RUN: begin
                if (cancel_w) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    if (is_div_q) begin
                        // Restoring step: keep the difference only when no borrow occurred.
                        acc_d = add_r[WIDTH+1] ? add_x[WIDTH-1:0] : add_r[WIDTH-1:0];
                        qr_d  = {qr_q[WIDTH-2:0], ~add_r[WIDTH+1]};
                    end else begin
                        acc_d = add_r[WIDTH:1];
                        qr_d  = {add_r[0], qr_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH-1)) begin
                        state_d = S_FIX;
                        cnt_d   = '0;
                    end
                end
            end
            S_FIX: begin
                if (cancel_w) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    if (!is_div_q) begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end else if (dz_q) begin
                        hi_d = aorig_q;
                        lo_d = '1;
                    end else begin
                        hi_d = cond_neg(acc_q, neg_rem_q);
                        lo_d = cond_neg(qr_q, neg_res_q);
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Operand/datapath registers are only meaningful once an op has been launched.
    always_ff @(posedge clk) begin
        acc_q     <= acc_d;
        qr_q      <= qr_d;
        m_q       <= m_d;
        aorig_q   <= aorig_d;
        is_div_q  <= is_div_d;
        neg_res_q <= neg_res_d;
        neg_rem_q <= neg_rem_d;
        dz_q      <= dz_d;
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (WIDTH=32); cancel steps only with MULDIV_CANCEL_EN.
module tb_muldiv_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, mthi, mtlo;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
`ifdef MULDIV_CANCEL_EN
    logic         cancel;
`endif
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;
    int edges;
    int pulses;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
`ifdef MULDIV_CANCEL_EN
        .cancel(cancel),
`endif
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives start for exactly one edge, then scrambles operands to prove they are latched.
    task automatic launch(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        op = o; a = av; b = bv; start = 1'b1;
        tick();
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    endtask

    // Counts edges after the start edge until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        n_cmp++;
        assert (done === 1'b1) else begin
            n_err++;
            $error("FAIL done_timeout: observed %0d edges expected done", n);
        end
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] ehi, input logic [W-1:0] elo);
        int n;
        launch(o, av, bv);
        wait_done(n);
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; a = '0; b = '0; wdata = '0;
`ifdef MULDIV_CANCEL_EN
        cancel = 1'b0;
`endif
        tick(); tick();
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        reset = 1'b0;
        tick();

        // MULTU max*max, with latency and hold checks
        launch(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("t1_busy_start", W'(busy), 32'd1);
        tick(); tick(); tick();
        chk("t1_hi_hold", hi, '0);
        chk("t1_done_early", W'(done), '0);
        edges = 3;
        while (!done && edges < 100) begin
            tick();
            edges++;
        end
        chk("t1_latency_edges_incl_start", W'(edges + 1), W'(W + 2));
        chk("t1_busy_done", W'(busy), 32'd1);
        chk("t1_hi", hi, 32'hFFFF_FFFE);
        chk("t1_lo", lo, 32'h0000_0001);
        tick();
        chk("t1_done_drop", W'(done), '0);
        chk("t1_busy_drop", W'(busy), '0);

        // Signed and unsigned arithmetic
        run_op("mult_m3x7", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_m3xm7", MULT, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h0, 32'd21);
        run_op("div_m7d2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7dm2", DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        run_op("divu_100d7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("multu_big", MULTU, 32'h8000_0001, 32'd4, 32'd2, 32'd4);

        // Divide by zero and signed overflow
        run_op("divu_by0", DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        run_op("div_m5_by0", DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // MTHI in IDLE, start beating MTHI, MTLO and second start ignored while busy
        mthi = 1'b1; wdata = 32'h1234;
        tick();
        mthi = 1'b0;
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_lo_keep", lo, 32'h8000_0000);
        mthi = 1'b1; wdata = 32'hABCD;
        launch(MULTU, 32'd2, 32'd3);
        mthi = 1'b0;
        chk("start_wins_hi", hi, 32'h1234);
        tick(); tick();
        mtlo = 1'b1; wdata = 32'hDEAD;
        tick();
        mtlo = 1'b0;
        chk("mtlo_busy_lo", lo, 32'h8000_0000);
        op = DIV; a = 32'd9; b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(edges);
        chk("t4_hi", hi, 32'h0);
        chk("t4_lo", lo, 32'd6);
        count_done(45, pulses);
        chk("t4_single_done", W'(pulses), 32'd0);
        chk("t4_idle", W'(busy), '0);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h77;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        chk("mt_both_hi", hi, 32'h77);
        chk("mt_both_lo", lo, 32'h77);

        // Async reset mid-RUN
        launch(MULTU, 32'd5, 32'd5);
        for (int i = 0; i < 11; i++) tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", W'(busy), '0);
        chk("arst_done", W'(done), '0);
        chk("arst_hi", hi, '0);
        chk("arst_lo", lo, '0);
        tick();
        reset = 1'b0;
        tick();
        run_op("after_rst_divu", DIVU, 32'd50, 32'd7, 32'd1, 32'd7);

`ifdef MULDIV_CANCEL_EN
        run_op("pre_cancel", MULTU, 32'd3, 32'd4, 32'd0, 32'd12);
        launch(DIVU, 32'd50, 32'd7);
        for (int i = 0; i < 5; i++) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel_busy", W'(busy), '0);
        count_done(40, pulses);
        chk("cancel_no_done", W'(pulses), 32'd0);
        chk("cancel_hi", hi, 32'd0);
        chk("cancel_lo", lo, 32'd12);
        cancel = 1'b1;
        launch(DIVU, 32'd9, 32'd2);
        cancel = 1'b0;
        chk("cancel_start_drop", W'(busy), '0);
        run_op("rerun_divu", DIVU, 32'd50, 32'd7, 32'd1, 32'd7);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
